// File: rtl/kernel_table_loader.sv
// Kernel table write-side master: packs host stream words into table lines.
// Optional: define KERNEL_TABLE_LOADER_CHECKSUM_EN for an XOR checksum output.
module kernel_table_loader #(
  parameter int ADDR_WIDTH = 9,
  parameter int CONST_POINTER_WIDTH = 9,
  parameter int LOCATION_INFORMATION_POINTER_WIDTH = 9,
  parameter int CONTEXT_POINTER_WIDTH = 9,
  parameter int DATA_WIDTH = 32,
  localparam int LINE_WIDTH = 2*CONST_POINTER_WIDTH
    + LOCATION_INFORMATION_POINTER_WIDTH
    + CONTEXT_POINTER_WIDTH,
  localparam int WORDS =
    (LINE_WIDTH + DATA_WIDTH - 1) / DATA_WIDTH,
  localparam int WCW = (WORDS > 1) ? $clog2(WORDS) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  start_i,
  input  logic [ADDR_WIDTH-1:0] base_addr_i,
  input  logic [ADDR_WIDTH:0]   nr_of_entries_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  data_valid_i,
  output logic                  data_ready_o,
  output logic [ADDR_WIDTH-1:0] memory_write_addr_o,
  output logic [LINE_WIDTH-1:0] memory_line_o,
  output logic                  write_memory_en_o,
  output logic                  busy_o,
  output logic                  done_o
`ifdef KERNEL_TABLE_LOADER_CHECKSUM_EN
  ,
  output logic [LINE_WIDTH-1:0] checksum_o
`endif
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_WRITE,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [ADDR_WIDTH-1:0]       r_addr;
  logic [ADDR_WIDTH:0]         r_remaining;
  logic [WCW-1:0]              r_word_cnt;
  logic [WORDS*DATA_WIDTH-1:0] r_buf;
  logic [WORDS*DATA_WIDTH-1:0] w_buf_next;
  logic [ADDR_WIDTH-1:0]       r_mem_addr;
  logic [LINE_WIDTH-1:0]       r_mem_line;
  logic                        w_accept;
  logic                        w_last;
  logic                        w_start;

  assign w_start  = (r_state == S_IDLE) && start_i;
  assign w_accept = (r_state == S_LOAD) && data_valid_i;
  assign w_last   = (r_word_cnt == WCW'(WORDS-1));

  always_comb begin
    w_buf_next = r_buf;
    for (int k = 0; k < WORDS; k++) begin
      if (r_word_cnt == WCW'(k))
        w_buf_next[k*DATA_WIDTH +: DATA_WIDTH] = data_i;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:
        if (start_i)
          w_next = (nr_of_entries_i != '0) ? S_LOAD : S_DONE;
      S_LOAD:
        if (w_accept && w_last)
          w_next = S_WRITE;
      S_WRITE:
        w_next = (r_remaining != (ADDR_WIDTH+1)'(1))
          ? S_LOAD : S_DONE;
      S_DONE:
        w_next = S_IDLE;
      default:
        w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_addr      <= '0;
      r_remaining <= '0;
      r_word_cnt  <= '0;
      r_buf       <= '0;
      r_mem_addr  <= '0;
      r_mem_line  <= '0;
    end else begin
      if (w_start) begin
        r_addr      <= base_addr_i;
        r_remaining <= nr_of_entries_i;
        r_word_cnt  <= '0;
        r_buf       <= '0;
      end
      if (w_accept) begin
        r_buf <= w_buf_next;
        if (w_last) begin
          r_word_cnt <= '0;
          r_mem_addr <= r_addr;
          r_mem_line <= w_buf_next[LINE_WIDTH-1:0];
        end else begin
          r_word_cnt <= r_word_cnt + WCW'(1);
        end
      end
      if (r_state == S_WRITE) begin
        r_addr      <= r_addr + ADDR_WIDTH'(1);
        r_remaining <= r_remaining - (ADDR_WIDTH+1)'(1);
        r_word_cnt  <= '0;
      end
    end
  end

`ifdef KERNEL_TABLE_LOADER_CHECKSUM_EN
  logic [LINE_WIDTH-1:0] r_checksum;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)
      r_checksum <= '0;
    else if (w_start)
      r_checksum <= '0;
    else if (r_state == S_WRITE)
      r_checksum <= r_checksum ^ r_mem_line;
  end

  assign checksum_o = r_checksum;
`endif

  assign data_ready_o        = (r_state == S_LOAD);
  assign write_memory_en_o   = (r_state == S_WRITE);
  assign done_o              = (r_state == S_DONE);
  assign busy_o              = (r_state != S_IDLE);
  assign memory_write_addr_o = r_mem_addr;
  assign memory_line_o       = r_mem_line;

endmodule

// File: tb/tb_kernel_table_loader.sv
// Directed bench for kernel_table_loader with a write scoreboard.
// Checksum checks follow KERNEL_TABLE_LOADER_CHECKSUM_EN.
module tb_kernel_table_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_i = 1'b0;
  logic [8:0]  base_addr_i = '0;
  logic [9:0]  nr_of_entries_i = '0;
  logic [31:0] data_i = '0;
  logic        data_valid_i = 1'b0;
  logic        data_ready_o;
  logic [8:0]  memory_write_addr_o;
  logic [35:0] memory_line_o;
  logic        write_memory_en_o;
  logic        busy_o;
  logic        done_o;
`ifdef KERNEL_TABLE_LOADER_CHECKSUM_EN
  logic [35:0] checksum_o;
`endif

  kernel_table_loader dut (
    .clk_i               (clk),
    .rst_n_i             (rst_n),
    .start_i             (start_i),
    .base_addr_i         (base_addr_i),
    .nr_of_entries_i     (nr_of_entries_i),
    .data_i              (data_i),
    .data_valid_i        (data_valid_i),
    .data_ready_o        (data_ready_o),
    .memory_write_addr_o (memory_write_addr_o),
    .memory_line_o       (memory_line_o),
    .write_memory_en_o   (write_memory_en_o),
    .busy_o              (busy_o),
    .done_o              (done_o)
`ifdef KERNEL_TABLE_LOADER_CHECKSUM_EN
    ,
    .checksum_o          (checksum_o)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int strobes = 0;
  logic [44:0] sb_q[$];

  task automatic check(input logic [63:0] obs,
                       input logic [63:0] exp,
                       input string tag);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && write_memory_en_o) begin
      logic [44:0] e;
      strobes++;
      check({63'd0, data_ready_o}, 64'd0, "ready_in_write");
      if (sb_q.size() == 0) begin
        check(64'd1, 64'd0, "unexpected_strobe");
      end else begin
        e = sb_q.pop_front();
        check({55'd0, memory_write_addr_o}, {55'd0, e[44:36]},
              "write_addr");
        check({28'd0, memory_line_o}, {28'd0, e[35:0]}, "write_line");
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [8:0] b, input logic [9:0] n);
    start_i = 1'b1;
    base_addr_i = b;
    nr_of_entries_i = n;
    tick();
    start_i = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input int gap);
    logic acc;
    data_valid_i = 1'b0;
    repeat (gap) tick();
    data_i = w;
    data_valid_i = 1'b1;
    acc = 1'b0;
    for (int i = 0; i < 50 && !acc; i++) begin
      @(negedge clk);
      acc = data_ready_o;
      tick();
    end
    if (!acc) check(64'd0, 64'd1, "send_timeout");
    data_valid_i = 1'b0;
  endtask

  task automatic send_line(input logic [8:0] a,
                           input logic [35:0] ln,
                           input int maxgap);
    sb_q.push_back({a, ln});
    send_word(ln[31:0], $urandom_range(0, maxgap));
    send_word({28'd0, ln[35:32]}, $urandom_range(0, maxgap));
  endtask

  task automatic wait_done(input string tag);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      seen = done_o;
    end
    check({63'd0, seen}, 64'd1, tag);
    @(negedge clk);
    check({63'd0, busy_o}, 64'd0, "busy_after_done");
    check({63'd0, done_o}, 64'd0, "done_one_cycle");
  endtask

  logic [35:0] line_a, line_b, line_c, csum;
  logic [35:0] rl[3];
  int s0;

  initial begin
    line_a = 36'h123456789;
    line_b = 36'h0FEDCBA98;
    line_c = 36'hA5A5A5A5A;

    rst_n = 1'b0;
    for (int i = 0; i < 6; i++) begin
      start_i = $urandom_range(0, 1);
      data_valid_i = $urandom_range(0, 1);
      data_i = $urandom;
      base_addr_i = 9'($urandom);
      nr_of_entries_i = 10'($urandom);
      @(negedge clk);
      check({19'd0, data_ready_o, memory_write_addr_o, memory_line_o,
             write_memory_en_o, busy_o, done_o}, 64'd0, "reset_outs");
    end
    start_i = 1'b0;
    data_valid_i = 1'b0;
    tick();
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check({62'd0, busy_o, data_ready_o}, 64'd0, "idle_after_rst");
    end
    tick();

    s0 = strobes;
    do_start(9'd5, 10'd1);
    sb_q.push_back({9'd5, 36'hF89ABCDEF});
    send_word(32'h89ABCDEF, 0);
    send_word(32'h0000000F, 0);
    @(negedge clk);
    check({63'd0, write_memory_en_o}, 64'd1, "t1_strobe_now");
    @(negedge clk);
    check({63'd0, done_o}, 64'd1, "t1_done_next");
    check({63'd0, write_memory_en_o}, 64'd0, "t1_strobe_1cyc");
    @(negedge clk);
    check({63'd0, busy_o}, 64'd0, "t1_busy_low");
    check(64'(strobes - s0), 64'd1, "t1_strobes");
    check({28'd0, memory_line_o}, 64'hF89ABCDEF, "t1_line_hold");
`ifdef KERNEL_TABLE_LOADER_CHECKSUM_EN
    check({28'd0, checksum_o}, 64'hF89ABCDEF, "t1_checksum");
`endif
    tick();

    s0 = strobes;
    do_start(9'd511, 10'd2);
    send_line(9'd511, line_a, 0);
    send_line(9'd0, line_b, 0);
    wait_done("t2_done");
    check(64'(strobes - s0), 64'd2, "t2_strobes");
`ifdef KERNEL_TABLE_LOADER_CHECKSUM_EN
    check({28'd0, checksum_o}, {28'd0, line_a ^ line_b}, "t2_checksum");
`endif

    s0 = strobes;
    do_start(9'd33, 10'd0);
    @(negedge clk);
    check({63'd0, done_o}, 64'd1, "t3_done_1cyc");
    check({63'd0, data_ready_o}, 64'd0, "t3_no_ready");
    @(negedge clk);
    check({62'd0, done_o, data_ready_o}, 64'd0, "t3_after");
    check(64'(strobes - s0), 64'd0, "t3_no_strobe");
`ifdef KERNEL_TABLE_LOADER_CHECKSUM_EN
    check({28'd0, checksum_o}, 64'd0, "t3_checksum_clr");
`endif
    tick();

    for (int i = 0; i < 3; i++) rl[i] = {$urandom_range(0, 15), $urandom};
    s0 = strobes;
    do_start(9'd100, 10'd3);
    fork
      begin
        for (int i = 0; i < 3; i++) send_line(9'(100 + i), rl[i], 3);
      end
      begin
        repeat (4) tick();
        start_i = 1'b1;
        base_addr_i = 9'd7;
        nr_of_entries_i = 10'd1;
        tick();
        start_i = 1'b0;
      end
    join
    wait_done("t4_done");
    check(64'(strobes - s0), 64'd3, "t4_strobes");
    csum = rl[0] ^ rl[1] ^ rl[2];
`ifdef KERNEL_TABLE_LOADER_CHECKSUM_EN
    check({28'd0, checksum_o}, {28'd0, csum}, "t4_checksum");
`endif

    s0 = strobes;
    do_start(9'd50, 10'd2);
    send_word(32'hDEADBEEF, 0);
    rst_n = 1'b0;
    @(negedge clk);
    check({61'd0, busy_o, write_memory_en_o, data_ready_o}, 64'd0,
          "t5_rst_outs");
    tick();
    rst_n = 1'b1;
    tick();
    check(64'(strobes - s0), 64'd0, "t5_no_strobe");
    do_start(9'd0, 10'd1);
    send_line(9'd0, line_c, 1);
    wait_done("t5_done");
    check(64'(strobes - s0), 64'd1, "t5_strobes");
`ifdef KERNEL_TABLE_LOADER_CHECKSUM_EN
    check({28'd0, checksum_o}, {28'd0, line_c}, "t5_checksum");
`endif

    check(64'(sb_q.size()), 64'd0, "sb_empty");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: observed=timeout expected=finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/kernel_table_loader.md
Name: kernel_table_loader

Overview:
Write-side master for the CGRA kernel table memory. Accepts a stream of DATA_WIDTH words from the host/DMA via a valid/ready handshake and packs them into kernel table lines {nr_of_constants, constants_pointer, locationInformation_pointer, context_pointer}. Drives the table's write port (address, line, write enable) for a programmed number of consecutive entries. Signals completion to the host.

Parameters:
ADDR_WIDTH, 9, kernel table address width
CONST_POINTER_WIDTH, 9, width of nr_of_constants and constants_pointer fields
LOCATION_INFORMATION_POINTER_WIDTH, 9, width of locationInformation_pointer field
CONTEXT_POINTER_WIDTH, 9, width of context_pointer field
DATA_WIDTH, 32, host stream word width
(derived) LINE_WIDTH = 2*CONST_POINTER_WIDTH + LOCATION_INFORMATION_POINTER_WIDTH + CONTEXT_POINTER_WIDTH; WORDS = ceil(LINE_WIDTH/DATA_WIDTH)

Ports:
clk_i  in  1  clock, all logic on rising edge
rst_n_i  in  1  asynchronous active-low reset
start_i  in  1  start a load; sampled only in IDLE
base_addr_i  in  ADDR_WIDTH  first table address to write
nr_of_entries_i  in  ADDR_WIDTH+1  number of lines to write (0..2^ADDR_WIDTH)
data_i  in  DATA_WIDTH  stream word
data_valid_i  in  1  data_i valid
data_ready_o  out  1  loader accepts data_i this cycle
memory_write_addr_o  out  ADDR_WIDTH  table write address
memory_line_o  out  LINE_WIDTH  packed table line
write_memory_en_o  out  1  one-cycle table write strobe
busy_o  out  1  load in progress
done_o  out  1  one-cycle completion pulse

Behaviour:
- Reset (async assert, sync deassert): state IDLE; all outputs 0; word counter, entry counter, address, line buffer cleared.
- States: IDLE, LOAD, WRITE, DONE. busy_o = (state != IDLE).
- IDLE: start_i=1 latches base_addr_i, nr_of_entries_i; next state LOAD if count != 0, else DONE.
- LOAD: data_ready_o=1. Word accepted when data_valid_i && data_ready_o at the edge. Word k (0..WORDS-1) is placed at line bits [k*DATA_WIDTH +: DATA_WIDTH]; bits beyond LINE_WIDTH discarded. Gaps in data_valid_i hold state. On acceptance of word WORDS-1 -> WRITE.
- WRITE (exactly 1 cycle): write_memory_en_o=1, memory_write_addr_o = current address, memory_line_o = packed line; data_ready_o=0. Then address += 1 modulo 2^ADDR_WIDTH (511 wraps to 0), remaining count -= 1; word counter to 0; next LOAD if remaining != 0 else DONE.
- Throughput: WORDS+1 cycles per line at full valid rate.
- DONE (1 cycle): done_o=1, then IDLE. busy_o low in the cycle after done_o.
- memory_write_addr_o/memory_line_o are registered and hold their last value outside WRITE; only write_memory_en_o qualifies them.
- start_i while busy_o=1: ignored, no effect on the active load.
- data_valid_i in IDLE/DONE/WRITE: not accepted (data_ready_o=0), no state change.
- Reset mid-load: load aborted, no write strobe issued, partial line dropped.

Optional Feature:
KERNEL_TABLE_LOADER_CHECKSUM_EN: adds output checksum_o [LINE_WIDTH-1:0] = XOR of all lines written since the last accepted start_i; cleared to 0 on reset and on accepted start_i, updated in the WRITE cycle, stable when done_o is high. Without the macro: no port, no logic.

Test Plan:
- Reset with all inputs toggling -> all outputs 0, data_ready_o=0, busy_o=0 until start.
- Defaults, start base=5 count=1, words 0x89ABCDEF then 0x0000000F -> one write_memory_en_o pulse, addr 5, line 36'hF89ABCDEF (context_pointer=0x1EF); done_o one cycle later; checksum_o=36'hF89ABCDEF when enabled.
- start base=511 count=2, lines A=36'h123456789, B=36'h0FEDCBA98 -> writes at 511 then 0, exactly 2 strobes, done_o after second; checksum_o=A^B.
- start count=0 -> no write strobe, data_ready_o never 1, done_o exactly 1 cycle after start cycle.
- data_valid_i with random gaps and start_i pulsed while busy -> same lines/addresses as gap-free run; second start ignored; data_ready_o=0 during each WRITE cycle.
- Reset after first word of a 2-line load -> no strobe; subsequent start base=0 count=1 writes correct line at 0 with no leftover data.
